// File: rtl/alu_pipe_pkg.sv
// Shared op encodings and helpers for the two-stage ALU/parity pipeline.
// parity_of accepts results up to PAR_MAX_WIDTH bits; zero-extension does not change parity.
package alu_pipe_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    localparam int PAR_MAX_WIDTH = 64;

    // Each op bit is the OR of the instruction bits whose index has that bit set.
    function automatic logic [2:0] decode_instr(input logic [7:0] instr);
        logic [2:0] op;
        op[0] = instr[1] | instr[3] | instr[5] | instr[7];
        op[1] = instr[2] | instr[3] | instr[6] | instr[7];
        op[2] = instr[4] | instr[5] | instr[6] | instr[7];
        return op;
    endfunction

    function automatic logic parity_of(input logic [PAR_MAX_WIDTH-1:0] vec, input logic odd);
        return odd ? ^vec : ~^vec;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub at WIDTH+1 bits (MSB is carry/borrow), six bitwise ops.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] logic_res;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_res;
            always_comb begin
                bit_res = 1'b0;
                case (op)
                    OP_XOR:  bit_res = a[gi] ^ b[gi];
                    OP_OR:   bit_res = a[gi] | b[gi];
                    OP_AND:  bit_res = a[gi] & b[gi];
                    OP_NOR:  bit_res = ~(a[gi] | b[gi]);
                    OP_NAND: bit_res = ~(a[gi] & b[gi]);
                    OP_XNOR: bit_res = ~(a[gi] ^ b[gi]);
                    default: bit_res = 1'b0;
                endcase
            end
            assign logic_res[gi] = bit_res;
        end
    endgenerate

    // The extra MSB of the subtraction is set exactly when a < b (borrow).
    always_comb begin
        result = logic_res;
        carry  = 1'b0;
        case (op)
            OP_ADD:  {carry, result} = sum_ext;
            OP_SUB:  {carry, result} = diff_ext;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_parity_pipe.sv
// Two-stage valid/ready ALU pipeline with parity tag; stage 1 holds operands, stage 2 holds results.
// Optional one-hot instruction checker enabled by defining ALU_ONEHOT_CHECK_EN.
module alu_parity_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter bit PAR_ODD = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             parity,
    output logic             err
);

    logic             s1_v_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [2:0]       s1_op_reg;

    logic             s2_v_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             parity_reg;

    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic             parity_next;

    logic s2_ready;
    logic s1_load;
    logic s1_adv;

    assign s2_ready = !s2_v_reg || out_ready;
    assign in_ready = !s1_v_reg || s2_ready;
    assign s1_load  = in_valid && in_ready;
    assign s1_adv   = s1_v_reg && s2_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v_reg  <= 1'b0;
            s1_a_reg  <= '0;
            s1_b_reg  <= '0;
            s1_op_reg <= OP_ADD;
        end else begin
            if (in_ready) begin
                s1_v_reg <= in_valid;
            end
            if (s1_load) begin
                s1_a_reg  <= a;
                s1_b_reg  <= b;
                s1_op_reg <= decode_instr(instr);
            end
        end
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .a      (s1_a_reg),
        .b      (s1_b_reg),
        .op     (s1_op_reg),
        .result (result_next),
        .carry  (carry_next)
    );

    assign parity_next = parity_of(PAR_MAX_WIDTH'(result_next), PAR_ODD);

    // Result fields only load on an actual advance so they hold while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_v_reg   <= 1'b0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            parity_reg <= PAR_ODD ? 1'b0 : 1'b1;
        end else begin
            if (s2_ready) begin
                s2_v_reg <= s1_v_reg;
            end
            if (s1_adv) begin
                result_reg <= result_next;
                carry_reg  <= carry_next;
                parity_reg <= parity_next;
            end
        end
    end

`ifdef ALU_ONEHOT_CHECK_EN
    logic s1_chk_reg;
    logic err_reg;
    logic chk_next;

    assign chk_next = (instr != 8'd0) && ((instr & (instr - 8'd1)) != 8'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_chk_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_chk_reg <= chk_next;
            end
            if (s1_adv) begin
                err_reg <= s1_chk_reg;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign out_valid = s2_v_reg;
    assign result    = result_reg;
    assign carry     = carry_reg;
    assign parity    = parity_reg;

endmodule

// File: tb/tb_alu_parity_pipe.sv
// Scoreboard bench for alu_parity_pipe (WIDTH=4, PAR_ODD=0); expected beats queued at acceptance.
module tb_alu_parity_pipe;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic [7:0] instr = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] result;
    logic       carry;
    logic       parity;
    logic       err;

`ifdef ALU_ONEHOT_CHECK_EN
    localparam logic MULTI_ERR = 1'b1;
`else
    localparam logic MULTI_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] result;
        logic       carry;
        logic       parity;
        logic       err;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    pop_cyc[$];
    int    acc_cyc[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    acc_cnt = 0;
    int    bp_done = 0;

    alu_parity_pipe #(
        .WIDTH   (4),
        .PAR_ODD (1'b0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .parity    (parity),
        .err       (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic beat_t mk(input logic [3:0] r, input logic c, input logic p, input logic e);
        beat_t t;
        t.result = r;
        t.carry  = c;
        t.parity = p;
        t.err    = e;
        return t;
    endfunction

    // Reference: op is the OR of the indices of all set instruction bits.
    function automatic beat_t model(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] ti);
        beat_t t;
        int op = 0;
        int bits = 0;
        int ones = 0;
        int s = 0;
        int ia = int'(ta);
        int ib = int'(tb_);
        for (int i = 0; i < 8; i++) begin
            if (ti[i]) begin
                op = op | i;
                bits++;
            end
        end
        t.carry = 1'b0;
        case (op)
            0: begin s = ia + ib; t.carry = (s > 15); end
            1: begin s = ia - ib + 16; t.carry = (ia < ib); end
            2: s = ia ^ ib;
            3: s = ia | ib;
            4: s = ia & ib;
            5: s = ~(ia | ib);
            6: s = ~(ia & ib);
            default: s = ~(ia ^ ib);
        endcase
        t.result = 4'(s & 15);
        for (int i = 0; i < 4; i++) ones += int'(t.result[i]);
        t.parity = ((ones % 2) == 0);
        t.err    = MULTI_ERR && (bits > 1);
        return t;
    endfunction

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got result %0h with no expected beat queued", result);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", result, mon_exp.result);
                check("carry",  carry,  mon_exp.carry);
                check("parity", parity, mon_exp.parity);
                check("err",    err,    mon_exp.err);
                $display("beat cyc=%0d result=%b carry=%b parity=%b err=%b", cyc, result, carry, parity, err);
            end
            pop_cyc.push_back(cyc);
        end
    end

    task automatic send(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] ti, input beat_t e);
        int w = 0;
        bit ok = 1'b1;
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        instr = ti;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            w++;
            if (w >= 64) begin
                ok = 1'b0;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 64 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        exp_q.push_back(e);
        acc_cnt++;
        #1;
        acc_cyc.push_back(cyc);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clock);
            w++;
        end
        @(posedge clock);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic clear_stamps();
        pop_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic check_consecutive(input string name, input int n);
        check({name, "_count"}, pop_cyc.size(), n);
        for (int i = 1; i < pop_cyc.size() && i < n; i++)
            check({name, "_gap"}, pop_cyc[i] - pop_cyc[i-1], 1);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] ri;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        check("rst_parity", parity, 1);
        check("rst_err", err, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Decode/ALU vectors plus latency
        clear_stamps();
        send(4'b1111, 4'b1110, 8'b0000_0000, mk(4'b1101, 1'b1, 1'b0, 1'b0));
        send(4'b1111, 4'b1110, 8'b0000_1000, mk(4'b1111, 1'b0, 1'b1, 1'b0));
        send(4'b1111, 4'b1110, 8'b1000_0000, mk(4'b1110, 1'b0, 1'b0, 1'b0));
        send(4'b0101, 4'b0010, 8'b0010_0000, mk(4'b1000, 1'b0, 1'b0, 1'b0));
        send(4'b1111, 4'b1110, 8'b0000_0001, mk(4'b1101, 1'b1, 1'b0, 1'b0));
        idle();
        drain();
        check("lat_count", pop_cyc.size(), acc_cyc.size());
        for (int i = 0; i < pop_cyc.size() && i < acc_cyc.size(); i++)
            check("latency", pop_cyc[i] - acc_cyc[i], 1);

        // Subtract and borrow
        send(4'b1111, 4'b1110, 8'b0000_0010, mk(4'b0001, 1'b0, 1'b0, 1'b0));
        send(4'b0001, 4'b0010, 8'b0000_0010, mk(4'b1111, 1'b1, 1'b1, 1'b0));
        idle();
        drain();

        // Backpressure: 4 beats, downstream stalled
        clear_stamps();
        out_ready = 1'b0;
        acc_cnt = 0;
        bp_done = 0;
        fork
            begin
                send(4'b0011, 4'b0101, 8'b0000_0000, mk(4'b1000, 1'b0, 1'b0, 1'b0));
                send(4'b1010, 4'b0110, 8'b0000_0100, mk(4'b1100, 1'b0, 1'b1, 1'b0));
                send(4'b1010, 4'b0110, 8'b0001_0000, mk(4'b0010, 1'b0, 1'b0, 1'b0));
                send(4'b1010, 4'b0110, 8'b0100_0000, mk(4'b1101, 1'b0, 1'b0, 1'b0));
                idle();
                bp_done = 1;
            end
        join_none
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("bp_accepted", acc_cnt, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_result", result, 4'b1000);
            check("stall_carry", carry, 0);
            check("stall_parity", parity, 0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        for (int w = 0; w < 200 && bp_done == 0; w++) @(posedge clock);
        check("bp_done", bp_done, 1);
        drain();
        check("bp_total_accepted", acc_cnt, 4);
        check_consecutive("bp_drain", 4);

        // Full-rate streaming
        clear_stamps();
        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            ri = 8'($urandom_range(0, 255));
            send(ra, rb, ri, model(ra, rb, ri));
        end
        idle();
        drain();
        check_consecutive("stream", 16);

        // Async reset with two beats in flight
        out_ready = 1'b0;
        send(4'b0011, 4'b0101, 8'b0000_0000, mk(4'b1000, 1'b0, 1'b0, 1'b0));
        send(4'b1010, 4'b0110, 8'b0000_0100, mk(4'b1100, 1'b0, 1'b1, 1'b0));
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("inflight_out_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_result", result, 0);
        check("arst_carry", carry, 0);
        check("arst_parity", parity, 1);
        check("arst_err", err, 0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_empty", out_valid, 0);
        out_ready = 1'b1;
        send(4'b0011, 4'b0001, 8'b0000_0000, mk(4'b0100, 1'b0, 1'b0, 1'b0));
        idle();
        drain();

        // One-hot checker
        send(4'b1100, 4'b0011, 8'b0000_0110, mk(4'b1111, 1'b0, 1'b1, MULTI_ERR));
        send(4'b1100, 4'b0011, 8'b0000_0100, mk(4'b1111, 1'b0, 1'b1, 1'b0));
        send(4'b1100, 4'b0011, 8'b1111_1111, model(4'b1100, 4'b0011, 8'b1111_1111));
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
